quad_decoder: RTL and testbench

- Receive-side counterpart to the joystick-to-quadrature generator. Takes a two-phase quadrature signal from a physical spinner/paddle on USER_IN pins, or from a generator loopback, and converts it into an absolute saturating paddle position plus a signed read-and-clear delta.
- Sits in the emu top level, in the clk_sys domain, between the raw encoder pins and the core's Paddle/position inputs.

---
 rtl/quad_pkg.sv | 29 ++
 rtl/quad_filter.sv | 57 +++++
 rtl/quad_decoder.sv | 162 ++++++++++++++++
 tb/tb_quad_decoder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and the quadrature transition decoder used by quad_decoder.
package quad_pkg;

  typedef logic [1:0] quad_state_t;

  typedef enum logic {INIT, RUN} fsm_t;

  typedef struct packed {
    logic valid;
    logic up;
    logic illegal;
  } step_info_t;

  // Up order is 00->01->11->10->00, so the next-up state of {a,b} is {b,~a}.
  function automatic step_info_t quad_step(input quad_state_t prev, input quad_state_t cur);
    step_info_t r;
    quad_state_t diff;
    r = '0;
    diff = prev ^ cur;
    if (diff == 2'b11) begin
      r.illegal = 1'b1;
    end else if (diff != 2'b00) begin
      r.valid = 1'b1;
      r.up    = (cur == {prev[0], ~prev[1]});
    end
    return r;
  endfunction

endpackage

// File: rtl/quad_filter.sv
// Two-flop synchronizer plus ce-paced debounce for one encoder phase.
module quad_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk_sys,
  input  logic Reset_n,
  input  logic ce,
  input  logic raw,
  output logic level,
  output logic stable
);

  localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);
  localparam logic [3:0] CNT_FULL = 4'(FILT_LEN);

  logic       meta_q;
  logic       sync_q;
  logic [3:0] cnt_q;
  logic [3:0] calm_q;

  always_ff @(posedge clk_sys or negedge Reset_n) begin
    if (!Reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
    end
  end

  // calm_q counts agreeing samples so the decoder can tell when the input has settled
  always_ff @(posedge clk_sys or negedge Reset_n) begin
    if (!Reset_n) begin
      level  <= 1'b0;
      cnt_q  <= '0;
      calm_q <= '0;
    end else if (ce) begin
      if (sync_q != level) begin
        calm_q <= '0;
        if (cnt_q == CNT_LAST) begin
          level <= sync_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
      end else begin
        cnt_q <= '0;
        if (calm_q != CNT_FULL) begin
          calm_q <= calm_q + 4'd1;
        end
      end
    end
  end

  assign stable = (calm_q == CNT_FULL);

endmodule

// File: rtl/quad_decoder.sv
// Quadrature receiver: debounced phases in, saturating position and read-and-clear delta out.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int FILT_LEN = 4,
  parameter int POS_W    = 8,
  parameter int POS_MIN  = 0,
  parameter int POS_MAX  = 255
) (
  input  logic                    clk_sys,
  input  logic                    Reset_n,
  input  logic                    ce,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic                    center,
  input  logic                    delta_rd,
  output logic [POS_W-1:0]        position,
  output logic signed [7:0]       delta,
  output logic                    step,
  output logic                    dir,
  output logic                    err,
  output logic [7:0]              err_cnt
);

  localparam int EXT_W = POS_W + 2;
  localparam logic signed [EXT_W-1:0] MIN_EXT    = EXT_W'(POS_MIN);
  localparam logic signed [EXT_W-1:0] MAX_EXT    = EXT_W'(POS_MAX);
  localparam logic [POS_W-1:0]        CENTER_POS = POS_W'((POS_MIN + POS_MAX) >> 1);

  logic        filt_a, filt_b;
  logic        stable_a, stable_b;
  quad_state_t cur_ab;
  quad_state_t prev_q, prev_d;
  fsm_t        state_q, state_d;
  step_info_t  dec;

  logic signed [EXT_W-1:0] inc_ext;
  logic signed [EXT_W-1:0] pos_ext;
  logic [POS_W-1:0]        position_q, pos_d;
  logic signed [7:0]       acc_q, acc_d, inc8;

  quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk_sys (clk_sys),
    .Reset_n (Reset_n),
    .ce      (ce),
    .raw     (enc_a),
    .level   (filt_a),
    .stable  (stable_a)
  );

  quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk_sys (clk_sys),
    .Reset_n (Reset_n),
    .ce      (ce),
    .raw     (enc_b),
    .level   (filt_b),
    .stable  (stable_b)
  );

  always_ff @(posedge clk_sys or negedge Reset_n) begin
    if (!Reset_n) begin
      cur_ab <= '0;
    end else begin
      cur_ab <= {filt_a, filt_b};
    end
  end

  always_ff @(posedge clk_sys or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= INIT;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
    end
  end

  // INIT adopts the resting phase state silently so a non-00 rest cannot count or flag
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    dec     = '0;
    if (ce) begin
      case (state_q)
        INIT: begin
          if (stable_a && stable_b) begin
            prev_d  = cur_ab;
            state_d = RUN;
          end
        end
        RUN: begin
          if (cur_ab != prev_q) begin
            dec    = quad_step(prev_q, cur_ab);
            prev_d = cur_ab;
          end
        end
        default: state_d = INIT;
      endcase
    end
  end

  always_comb begin
    inc_ext = '0;
    if (dec.valid) begin
      inc_ext = dec.up ? EXT_W'(1) : '1;
    end
    pos_ext = $signed({2'b00, position_q}) + inc_ext;
    if (pos_ext > MAX_EXT) begin
      pos_d = MAX_EXT[POS_W-1:0];
    end else if (pos_ext < MIN_EXT) begin
      pos_d = MIN_EXT[POS_W-1:0];
    end else begin
      pos_d = pos_ext[POS_W-1:0];
    end
    if (center) begin
      pos_d = CENTER_POS;
    end
  end

  // A read reloads with this cycle's step so nothing arriving on the read edge is lost
  always_comb begin
    inc8 = '0;
    if (dec.valid) begin
      inc8 = dec.up ? 8'sh01 : 8'shFF;
    end
    if (delta_rd) begin
      acc_d = inc8;
    end else if (dec.valid && dec.up && acc_q == 8'sh7F) begin
      acc_d = acc_q;
    end else if (dec.valid && !dec.up && acc_q == 8'sh80) begin
      acc_d = acc_q;
    end else begin
      acc_d = acc_q + inc8;
    end
  end

  always_ff @(posedge clk_sys or negedge Reset_n) begin
    if (!Reset_n) begin
      position_q <= POS_W'(POS_MIN);
      acc_q      <= '0;
      step       <= 1'b0;
      err        <= 1'b0;
      dir        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      position_q <= pos_d;
      acc_q      <= acc_d;
      step       <= dec.valid;
      err        <= dec.illegal;
      if (dec.valid) begin
        dir <= dec.up;
      end
      if (dec.illegal && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  assign position = position_q;
  assign delta    = acc_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder with hand-computed expectations.
module tb_quad_decoder;

  logic              clk_sys;
  logic              Reset_n;
  logic              ce;
  logic              enc_a;
  logic              enc_b;
  logic              center;
  logic              delta_rd;
  logic [7:0]        position;
  logic signed [7:0] delta;
  logic              step;
  logic              dir;
  logic              err;
  logic [7:0]        err_cnt;

  int total;
  int bad;
  int steps_seen;
  int errs_seen;
  logic [1:0] ab;

  quad_decoder #(
    .FILT_LEN (4),
    .POS_W    (8),
    .POS_MIN  (0),
    .POS_MAX  (255)
  ) dut (
    .clk_sys  (clk_sys),
    .Reset_n  (Reset_n),
    .ce       (ce),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .center   (center),
    .delta_rd (delta_rd),
    .position (position),
    .delta    (delta),
    .step     (step),
    .dir      (dir),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check_output(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge
  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
      if (step === 1'b1) steps_seen++;
      if (err === 1'b1) errs_seen++;
    end
  endtask

  task automatic set_ab(input logic [1:0] v);
    ab    = v;
    enc_a = v[1];
    enc_b = v[0];
  endtask

  function automatic logic [1:0] next_up(input logic [1:0] s);
    return {s[0], ~s[1]};
  endfunction

  function automatic logic [1:0] next_dn(input logic [1:0] s);
    return {~s[0], s[1]};
  endfunction

  task automatic move_up(input int n);
    for (int i = 0; i < n; i++) begin
      set_ab(next_up(ab));
      hold(10);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    steps_seen = 0;
    errs_seen  = 0;
    ce         = 1'b1;
    center     = 1'b0;
    delta_rd   = 1'b0;
    Reset_n    = 1'b0;
    set_ab(2'b11);
    hold(3);
    check_output("rst_position", position, 0);
    check_output("rst_delta", delta, 0);
    check_output("rst_step", step, 0);
    check_output("rst_dir", dir, 0);
    check_output("rst_err", err, 0);
    check_output("rst_err_cnt", err_cnt, 0);

    Reset_n    = 1'b1;
    steps_seen = 0;
    errs_seen  = 0;
    hold(30);
    check_output("idle11_steps", steps_seen, 0);
    check_output("idle11_errs", errs_seen, 0);
    check_output("idle11_position", position, 0);

    Reset_n = 1'b0;
    set_ab(2'b00);
    hold(2);
    Reset_n = 1'b1;
    hold(20);
    steps_seen = 0;

    set_ab(2'b01);
    hold(7);
    check_output("lat_before", step, 0);
    hold(1);
    check_output("lat_edge", step, 1);
    check_output("lat_position", position, 1);
    hold(2);
    set_ab(2'b11);
    hold(10);
    set_ab(2'b10);
    hold(10);
    set_ab(2'b00);
    hold(10);
    check_output("up4_steps", steps_seen, 4);
    check_output("up4_dir", dir, 1);
    check_output("up4_position", position, 4);
    check_output("up4_delta", $signed(delta), 4);

    delta_rd = 1'b1;
    check_output("rd_value", $signed(delta), 4);
    hold(1);
    delta_rd = 1'b0;
    check_output("rd_cleared", $signed(delta), 0);

    move_up(3);
    check_output("up3_delta", $signed(delta), 3);
    check_output("up3_position", position, 7);

    set_ab(next_up(ab));
    hold(7);
    delta_rd = 1'b1;
    check_output("rd_step_value", $signed(delta), 3);
    hold(1);
    delta_rd = 1'b0;
    check_output("rd_step_keep", $signed(delta), 1);
    check_output("rd_step_position", position, 8);
    hold(2);

    move_up(300);
    check_output("sat_position", position, 255);
    check_output("sat_delta", $signed(delta), 127);

    center = 1'b1;
    hold(1);
    center = 1'b0;
    check_output("center_position", position, 127);

    steps_seen = 0;
    for (int i = 0; i < 5; i++) begin
      set_ab(next_dn(ab));
      hold(10);
    end
    check_output("down5_steps", steps_seen, 5);
    check_output("down5_position", position, 122);
    check_output("down5_delta", $signed(delta), 122);
    check_output("down5_dir", dir, 0);

    set_ab(next_up(ab));
    hold(7);
    center = 1'b1;
    hold(1);
    center = 1'b0;
    check_output("center_win_position", position, 127);
    check_output("center_win_delta", $signed(delta), 123);
    hold(2);

    steps_seen = 0;
    enc_a = ~ab[1];
    hold(3);
    enc_a = ab[1];
    hold(15);
    check_output("glitch3_steps", steps_seen, 0);
    check_output("glitch3_position", position, 127);

    enc_a = ~ab[1];
    hold(4);
    enc_a = ab[1];
    hold(15);
    check_output("glitch4_steps", steps_seen, 2);
    check_output("glitch4_position", position, 127);
    check_output("glitch4_delta", $signed(delta), 123);

    steps_seen = 0;
    errs_seen  = 0;
    set_ab(~ab);
    hold(10);
    check_output("err1_pulses", errs_seen, 1);
    check_output("err1_cnt", err_cnt, 1);
    check_output("err1_position", position, 127);
    check_output("err1_steps", steps_seen, 0);

    for (int i = 0; i < 299; i++) begin
      set_ab(~ab);
      hold(10);
    end
    check_output("err_pulses_total", errs_seen, 300);
    check_output("err_cnt_sat", err_cnt, 255);

    set_ab(next_up(ab));
    hold(3);
    #2;
    Reset_n = 1'b0;
    #1;
    check_output("async_position", position, 0);
    check_output("async_delta", $signed(delta), 0);
    check_output("async_err_cnt", err_cnt, 0);
    check_output("async_dir", dir, 0);
    check_output("async_step", step, 0);
    check_output("async_err", err, 0);
    hold(2);
    Reset_n = 1'b1;
    hold(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
